// File: rtl/demux_stream_1x4.sv
// 1-to-4 stream demux with a one-entry register per output slot.
// Define DEMUX_STAT_CNT_EN to enable per-slot 16-bit delivery counters.
module demux_stream_1x4 #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_bcast,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [63:0]         stat_cnt
);

  logic [3:0]             vld_q, vld_d;
  logic [3:0][DATA_W-1:0] data_q;
  logic [3:0]             can_acc;
  logic [3:0]             load;
  logic [3:0]             xfer;
  logic                   acc;

  // A full slot can take a new word only if it drains in the same edge.
  always_comb begin
    can_acc  = ~vld_q | out_ready;
    xfer     = vld_q & out_ready;
    in_ready = in_bcast ? (&can_acc) : can_acc[in_sel];
    acc      = in_valid & in_ready;
    load     = '0;
    for (int i = 0; i < 4; i++) begin
      load[i] = acc & (in_bcast | (in_sel == 2'(i)));
    end
    vld_d = load | (vld_q & ~out_ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < 4; i++) begin
        if (load[i]) data_q[i] <= in_data;
      end
    end
  end

  assign out_valid = vld_q;
  assign out_data  = data_q;

`ifdef DEMUX_STAT_CNT_EN
  logic [3:0][15:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (xfer[i]) cnt_q[i] <= cnt_q[i] + 16'd1;
      end
    end
  end

  assign stat_cnt = cnt_q;
`else
  logic unused_xfer;
  assign unused_xfer = ^xfer;
  assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_demux_stream_1x4.sv
// Random + directed bench for demux_stream_1x4 against a slot-queue model.
// Counter expectations follow DEMUX_STAT_CNT_EN.
module tb_demux_stream_1x4;

  logic         clk;
  logic         rst_n;
  logic [31:0]  in_data;
  logic [1:0]   in_sel;
  logic         in_bcast;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] out_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [63:0]  stat_cnt;

  demux_stream_1x4 #(.DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .stat_cnt  (stat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each slot is a queue of at most one word.
  logic [31:0] slot_q[4][$];
  logic [15:0] mcnt[4];
  int          xf0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_rdy();
    logic ok;
    if (in_bcast) begin
      ok = 1'b1;
      for (int i = 0; i < 4; i++)
        if (slot_q[i].size() != 0 && !out_ready[i]) ok = 1'b0;
    end else begin
      ok = (slot_q[in_sel].size() == 0) || out_ready[in_sel];
    end
    return ok;
  endfunction

  task automatic check_outs();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("vld%0d", i), 64'(out_valid[i]),
            64'(slot_q[i].size() != 0));
      if (slot_q[i].size() != 0)
        check($sformatf("dat%0d", i), 64'(out_data[i*32 +: 32]),
              64'(slot_q[i][0]));
`ifdef DEMUX_STAT_CNT_EN
      check($sformatf("cnt%0d", i), 64'(stat_cnt[i*16 +: 16]),
            64'(mcnt[i]));
`else
      check($sformatf("cnt%0d", i), 64'(stat_cnt[i*16 +: 16]), 64'd0);
`endif
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      slot_q[i].delete();
      mcnt[i] = 16'd0;
    end
    xf0 = 0;
  endtask

  // Called at negedge: drive, check, advance model over the next posedge.
  task automatic step(input logic v, input logic [1:0] s, input logic b,
                      input logic [31:0] d, input logic [3:0] r);
    logic rdy;
    in_valid  = v;
    in_sel    = s;
    in_bcast  = b;
    in_data   = d;
    out_ready = r;
    #1;
    rdy = model_rdy();
    check("in_ready", 64'(in_ready), 64'(rdy));
    check_outs();
    for (int i = 0; i < 4; i++) begin
      if (slot_q[i].size() != 0 && r[i]) begin
        void'(slot_q[i].pop_front());
        mcnt[i] = mcnt[i] + 16'd1;
        if (i == 0) xf0++;
      end
    end
    if (v && rdy) begin
      for (int i = 0; i < 4; i++)
        if (b || s == 2'(i)) slot_q[i].push_back(d);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  logic        pend;
  logic [1:0]  r_sel;
  logic        r_bc;
  logic [31:0] r_dat;
  int          guard;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_bcast  = 1'b0;
    in_data   = '0;
    out_ready = 4'b0000;
    model_clear();
    #3;
    check("rst_vld", 64'(out_valid), 64'd0);
    check("rst_dat_lo", out_data[63:0], 64'd0);
    check("rst_dat_hi", out_data[127:64], 64'd0);
    check("rst_cnt", stat_cnt, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset accepts; unicast to slot 2 with sinks stalled.
    step(1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 4'b0000);
    check("uc_vld", 64'(out_valid), 64'h4);
    check("uc_dat", 64'(out_data[95:64]), 64'hDEADBEEF);
    step(1'b0, 2'd2, 1'b0, 32'h0, 4'b0000);
    step(1'b0, 2'd0, 1'b0, 32'h0, 4'b1111);

    // Back-to-back into slot 1 with its sink always ready.
    step(1'b1, 2'd1, 1'b0, 32'hA, 4'b0010);
    step(1'b1, 2'd1, 1'b0, 32'hB, 4'b0010);
    step(1'b1, 2'd1, 1'b0, 32'hC, 4'b0010);
    step(1'b0, 2'd1, 1'b0, 32'h0, 4'b0010);
    step(1'b0, 2'd1, 1'b0, 32'h0, 4'b0010);

    // Broadcast blocked by a stalled slot 3, then released.
    step(1'b1, 2'd3, 1'b0, 32'h33, 4'b0000);
    step(1'b1, 2'd0, 1'b1, 32'h5, 4'b0000);
    step(1'b1, 2'd0, 1'b1, 32'h5, 4'b0000);
    step(1'b1, 2'd0, 1'b1, 32'h5, 4'b1000);
    for (int i = 0; i < 4; i++)
      check($sformatf("bc_dat%0d", i), 64'(out_data[i*32 +: 32]), 64'h5);
    step(1'b0, 2'd0, 1'b0, 32'h0, 4'b1111);

    // Async reset with slots 0 and 2 holding words.
    step(1'b1, 2'd0, 1'b0, 32'h11, 4'b0000);
    step(1'b1, 2'd2, 1'b0, 32'h22, 4'b0000);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld", 64'(out_valid), 64'd0);
    check("arst_cnt", stat_cnt, 64'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic obeying the source hold rules.
    pend = 1'b0;
    r_sel = 2'd0;
    r_bc = 1'b0;
    r_dat = '0;
    for (int n = 0; n < 1500; n++) begin
      logic v;
      logic [3:0] r;
      if (!pend) begin
        r_sel = 2'($urandom_range(0, 3));
        r_bc  = ($urandom_range(0, 3) == 0);
        r_dat = $urandom;
        v     = ($urandom_range(0, 2) != 0);
      end else begin
        v = 1'b1;
      end
      r = 4'($urandom);
      in_bcast = r_bc;
      in_sel = r_sel;
      out_ready = r;
      #1;
      pend = v && !model_rdy();
      step(v, r_sel, r_bc, r_dat, r);
    end

    // Counter wrap: 65535 transfers on slot 0 from a fresh reset, then one more.
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    guard = 0;
    while (xf0 < 65535 && guard < 70000) begin
      step(1'b1, 2'd0, 1'b0, $urandom, 4'b0001);
      guard++;
    end
    check("wrap_pre", 64'(xf0), 64'd65535);
    step(1'b0, 2'd0, 1'b0, 32'h0, 4'b0001);
    check("wrap_cnt0", 64'(stat_cnt[15:0]), 64'd0);
    check("wrap_oth", 64'(stat_cnt[63:16]), 64'd0);
    step(1'b0, 2'd0, 1'b0, 32'h0, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
